ram_port_arbiter: RTL and testbench

- Two-requester front end for the 16-entry x 4-bit single-port RAM.
- Arbitrates round-robin between requester A and requester B.
- Sequences one RAM access at a time: drives the RAM's en/wr/addr/indata and captures read data.
- Returns read data to the requester that issued the read. Sits between two client blocks and the RAM instance.

---
 rtl/ram_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-requester round-robin front end for a 16 x 4 single-port RAM.
// Serializes accesses through IDLE -> ISSUE (-> CAPTURE for reads) and returns
// read data to the requester that issued the read. All outputs are registered.
module ram_port_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_a,
   input  logic              req_b,
   input  logic              wr_a,
   input  logic              wr_b,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic [DATA_W-1:0] wdata_b,
   output logic              gnt_a,
   output logic              gnt_b,
   output logic              rvalid_a,
   output logic              rvalid_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic              busy,
   output logic              ram_en,
   output logic              ram_wr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_indata,
   input  logic [DATA_W-1:0] ram_outdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t state, state_next;

   // last_b = 1 means B was served most recently, so A wins the next tie.
   logic last_b, last_b_next;
   // Requester that owns the access in flight (0 = A, 1 = B).
   logic owner_b, owner_b_next;

   logic sel_a, sel_b;

   // Next values of the registered outputs.
   logic              gnt_a_next, gnt_b_next;
   logic              rvalid_a_next, rvalid_b_next;
   logic [DATA_W-1:0] rdata_a_next, rdata_b_next;
   logic              busy_next;
   logic              ram_en_next, ram_wr_next;
   logic [ADDR_W-1:0] ram_addr_next;
   logic [DATA_W-1:0] ram_indata_next;

   // Round-robin pick in IDLE: a lone request wins, a tie goes to whoever was not served last.
   always_comb begin
      sel_a = 1'b0;
      sel_b = 1'b0;
      if (state == IDLE) begin
         sel_a = req_a && (!req_b || last_b);
         sel_b = req_b && !sel_a;
      end
   end

   // Next-state and next-output logic; the ram_* registers double as the latched request.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
      state_next      = state;
      last_b_next     = last_b;
      owner_b_next    = owner_b;
      gnt_a_next      = 1'b0;
      gnt_b_next      = 1'b0;
      rvalid_a_next   = 1'b0;
      rvalid_b_next   = 1'b0;
      rdata_a_next    = rdata_a;
      rdata_b_next    = rdata_b;
      ram_en_next     = 1'b0;
      ram_wr_next     = 1'b0;
      ram_addr_next   = ram_addr;
      ram_indata_next = ram_indata;

      unique case (state)
         IDLE: begin
            if (sel_a) begin
               gnt_a_next      = 1'b1;
               ram_en_next     = 1'b1;
               ram_wr_next     = wr_a;
               ram_addr_next   = addr_a;
               ram_indata_next = wdata_a;
               owner_b_next    = 1'b0;
               last_b_next     = 1'b0;
               state_next      = ISSUE;
            end else if (sel_b) begin
               gnt_b_next      = 1'b1;
               ram_en_next     = 1'b1;
               ram_wr_next     = wr_b;
               ram_addr_next   = addr_b;
               ram_indata_next = wdata_b;
               owner_b_next    = 1'b1;
               last_b_next     = 1'b1;
               state_next      = ISSUE;
            end
         end
         ISSUE: begin
            // ram_wr still holds the latched operation during ISSUE.
            state_next = ram_wr ? IDLE : CAPTURE;
         end
         CAPTURE: begin
            // ram_outdata is only looked at here, so idle X from the RAM never reaches rdata.
            if (owner_b) begin
               rdata_b_next  = ram_outdata;
               rvalid_b_next = 1'b1;
            end else begin
               rdata_a_next  = ram_outdata;
               rvalid_a_next = 1'b1;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);
   end

   // State, arbitration pointer and registered outputs; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_b     <= 1'b1;
         owner_b    <= 1'b0;
         gnt_a      <= 1'b0;
         gnt_b      <= 1'b0;
         rvalid_a   <= 1'b0;
         rvalid_b   <= 1'b0;
         rdata_a    <= '0;
         rdata_b    <= '0;
         busy       <= 1'b0;
         ram_en     <= 1'b0;
         ram_wr     <= 1'b0;
         ram_addr   <= '0;
         ram_indata <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from pre-edge values.
         state      <= state_next;
         last_b     <= last_b_next;
         owner_b    <= owner_b_next;
         gnt_a      <= gnt_a_next;
         gnt_b      <= gnt_b_next;
         rvalid_a   <= rvalid_a_next;
         rvalid_b   <= rvalid_b_next;
         rdata_a    <= rdata_a_next;
         rdata_b    <= rdata_b_next;
         busy       <= busy_next;
         ram_en     <= ram_en_next;
         ram_wr     <= ram_wr_next;
         ram_addr   <= ram_addr_next;
         ram_indata <= ram_indata_next;
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: bench for ram_port_arbiter with a behavioural 16 x 4 RAM,
// a reference memory and per-requester queues of expected read data.
module tb_ram_port_arbiter;

   localparam int AW = 4;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_a, req_b, wr_a, wr_b;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] wdata_a, wdata_b;
   logic          gnt_a, gnt_b, rvalid_a, rvalid_b, busy;
   logic [DW-1:0] rdata_a, rdata_b;
   logic          ram_en, ram_wr;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_indata, ram_outdata;

   always #5 clk = ~clk;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .req_b(req_b), .wr_a(wr_a), .wr_b(wr_b),
      .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
      .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy),
      .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
      .ram_indata(ram_indata), .ram_outdata(ram_outdata)
   );

   // Behavioural single-port RAM: synchronous write, registered read, X when not reading.
   logic [DW-1:0] ram_mem [16];
   always @(posedge clk) begin
      if (ram_en && ram_wr) ram_mem[ram_addr] <= ram_indata;
      if (ram_en && !ram_wr) ram_outdata <= ram_mem[ram_addr];
      else                   ram_outdata <= 'x;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard state.
   logic [DW-1:0] model_mem [16];
   logic [DW-1:0] exp_a [$];
   logic [DW-1:0] exp_b [$];
   byte           glog [$];
   int            cyc = 0;
   int            rv_count = 0;
   int            en_count = 0;
   int            rv_cyc_a = -1;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: sampled on the falling edge, pops expected read data on each rvalid.
   always @(negedge clk) begin
      if (gnt_a || gnt_b) check("single_gnt", {31'd0, gnt_a & gnt_b}, 32'd0);
      if (gnt_a) glog.push_back("A");
      if (gnt_b) glog.push_back("B");
      if (ram_en) en_count++;
      if (rvalid_a) begin
         rv_count++;
         rv_cyc_a = cyc;
         if (exp_a.size() == 0) check("rvalid_a_unexpected", 32'd1, 32'd0);
         else check("rdata_a", {28'd0, rdata_a}, {28'd0, exp_a.pop_front()});
      end
      if (rvalid_b) begin
         rv_count++;
         if (exp_b.size() == 0) check("rvalid_b_unexpected", 32'd1, 32'd0);
         else check("rdata_b", {28'd0, rdata_b}, {28'd0, exp_b.pop_front()});
      end
   end

   // One access by requester who (0 = A, 1 = B): hold the request until granted,
   // check the RAM-side control in the grant cycle, update the reference model.
   task automatic access(input bit who, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int t0, output int tg);
      int  n;
      logic g;
      if (who) begin req_b = 1'b1; wr_b = w; addr_b = a; wdata_b = d; end
      else     begin req_a = 1'b1; wr_a = w; addr_a = a; wdata_a = d; end
      t0 = cyc;
      n  = 0;
      do begin
         @(negedge clk);
         n++;
         g = who ? gnt_b : gnt_a;
      end while (!g && n < 60);
      tg = cyc;
      if (!g) begin
         check(who ? "gnt_b_timeout" : "gnt_a_timeout", 32'd0, 32'd1);
      end else begin
         check("issue_en", {31'd0, ram_en}, 32'd1);
         check("issue_wr", {31'd0, ram_wr}, {31'd0, w});
         check("issue_addr", {28'd0, ram_addr}, {28'd0, a});
         check("issue_busy", {31'd0, busy}, 32'd1);
         if (w) begin
            check("issue_wdata", {28'd0, ram_indata}, {28'd0, d});
            model_mem[a] = d;
         end else if (who) exp_b.push_back(model_mem[a]);
         else              exp_a.push_back(model_mem[a]);
      end
      #1;
      if (who) req_b = 1'b0;
      else     req_a = 1'b0;
   endtask

   // Wait (bounded) until the arbiter is back in IDLE, plus one spare cycle.
   task automatic settle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("settle_timeout", {31'd0, busy}, 32'd0);
      @(negedge clk);
   endtask

   int t0, tg, t0b, tgb;
   logic [DW-1:0] snap_a, snap_b;
   int snap_rv, snap_en;

   initial begin
      rst = 1'b1;
      req_a = 0; req_b = 0; wr_a = 0; wr_b = 0;
      addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
      repeat (2) @(negedge clk);
      check("reset_ctrl", {25'd0, gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_en, ram_wr}, 32'd0);
      check("reset_data", {16'd0, rdata_a, rdata_b, ram_addr, ram_indata}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // A writes 4'hA to addr 3, then reads it back.
      access(1'b0, 1'b1, 4'd3, 4'hA, t0, tg);
      check("wr_gnt_latency", tg - t0, 32'd1);
      settle();
      access(1'b0, 1'b0, 4'd3, 4'h0, t0, tg);
      check("rd_gnt_latency", tg - t0, 32'd1);
      settle();
      check("rvalid_latency", rv_cyc_a - t0, 32'd3);
      check("rdata_b_untouched", {28'd0, rdata_b}, 32'd0);

      // Preload 1 by A and 2 by B (B served last), then both hammer reads.
      access(1'b0, 1'b1, 4'd1, 4'h1, t0, tg);
      settle();
      access(1'b1, 1'b1, 4'd2, 4'h2, t0, tg);
      settle();
      glog.delete();
      fork
         begin
            access(1'b0, 1'b0, 4'd1, 4'h0, t0, tg);
            access(1'b0, 1'b0, 4'd1, 4'h0, t0, tg);
         end
         begin
            access(1'b1, 1'b0, 4'd2, 4'h0, t0b, tgb);
            access(1'b1, 1'b0, 4'd2, 4'h0, t0b, tgb);
         end
      join
      settle();
      check("rr_count", glog.size(), 32'd4);
      check("rr_order", {glog[0], glog[1], glog[2], glog[3]}, {"A", "B", "A", "B"});
      check("rr_rdata_a", {28'd0, rdata_a}, 32'h1);
      check("rr_rdata_b", {28'd0, rdata_b}, 32'h2);

      // B writes 5 to addr 7, A reads addr 7 one cycle later.
      glog.delete();
      fork
         access(1'b1, 1'b1, 4'd7, 4'h5, t0b, tgb);
         begin
            @(negedge clk);
            access(1'b0, 1'b0, 4'd7, 4'h0, t0, tg);
         end
      join
      settle();
      check("wr_rd_first", {24'd0, glog[0]}, {24'd0, "B"});
      check("wr_rd_rdata_a", {28'd0, rdata_a}, 32'h5);

      // Idle for 10 cycles with X on ram_outdata.
      snap_a = rdata_a; snap_b = rdata_b; snap_rv = rv_count; snap_en = en_count;
      repeat (10) @(negedge clk);
      check("idle_rdata_a", {28'd0, rdata_a}, {28'd0, snap_a});
      check("idle_rdata_b", {28'd0, rdata_b}, {28'd0, snap_b});
      check("idle_rvalid", rv_count, snap_rv);
      check("idle_ram_en", en_count, snap_en);

      // Reset during CAPTURE of an A read.
      access(1'b0, 1'b0, 4'd3, 4'h0, t0, tg);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_ctrl", {25'd0, gnt_a, gnt_b, rvalid_a, rvalid_b, busy, ram_en, ram_wr}, 32'd0);
      check("abort_data", {16'd0, rdata_a, rdata_b, ram_addr, ram_indata}, 32'd0);
      void'(exp_a.pop_back());
      snap_rv = rv_count;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_no_rvalid", rv_count, snap_rv);
      check("abort_no_en", {31'd0, ram_en}, 32'd0);
      glog.delete();
      fork
         access(1'b0, 1'b0, 4'd1, 4'h0, t0, tg);
         access(1'b1, 1'b0, 4'd2, 4'h0, t0b, tgb);
      join
      settle();
      check("post_reset_tie", {24'd0, glog[0]}, {24'd0, "A"});

      // A write/read bursts across all 16 addresses, then 15 -> 0 wrap.
      for (int i = 0; i < 16; i++) begin
         access(1'b0, 1'b1, i[3:0], i[3:0] ^ 4'hF, t0, tg);
         access(1'b0, 1'b0, i[3:0], 4'h0, t0, tg);
      end
      access(1'b0, 1'b0, 4'd15, 4'h0, t0, tg);
      access(1'b0, 1'b0, 4'd0, 4'h0, t0, tg);
      settle();
      check("final_busy", {31'd0, busy}, 32'd0);
      check("final_rdata_a", {28'd0, rdata_a}, 32'hF);
      check("pending_a", exp_a.size(), 32'd0);
      check("pending_b", exp_b.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
